fifo_wr_ctrl: RTL and testbench

FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

---
 rtl/fifo_wr_ctrl_if.sv | 26 ++
 rtl/fifo_wr_ctrl.sv | 83 ++++++++
 tb/tb_fifo_wr_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_ctrl_if.sv
// Write-side bundle of the async FIFO: producer handshake, status flags, and the
// Gray pointers exchanged with the read domain.
interface fifo_wr_ctrl_if #(
    parameter int P_SIZE = 5
);
    logic                w_inc;
    logic                w_ovf_clr;
    logic [P_SIZE-1:0]   r_gptr;
    logic [P_SIZE-2:0]   w_addr;
    logic [P_SIZE-1:0]   w_gptr;
    logic                w_full;
    logic                w_almost_full;
    logic [P_SIZE-1:0]   w_level;
    logic                w_overflow;

    // master: producer plus read-domain pointer source; slave: the write controller
    modport master (
        output w_inc, w_ovf_clr, r_gptr,
        input  w_addr, w_gptr, w_full, w_almost_full, w_level, w_overflow
    );

    modport slave (
        input  w_inc, w_ovf_clr, r_gptr,
        output w_addr, w_gptr, w_full, w_almost_full, w_level, w_overflow
    );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Write-domain pointer and flag logic of an asynchronous FIFO: binary/Gray write
// pointer, two-flop read-pointer synchronizer, full/almost-full/level and sticky overflow.
module fifo_wr_ctrl #(
    parameter int P_SIZE   = 5,
    parameter int AF_LEVEL = 12
) (
    input  logic          w_clk,
    input  logic          w_rstn,
    fifo_wr_ctrl_if.slave bus
);
    localparam logic [P_SIZE-1:0] AF_THRESH = P_SIZE'(AF_LEVEL);

    logic [P_SIZE-1:0] wbin;
    logic [P_SIZE-1:0] wbin_next;
    logic [P_SIZE-1:0] wgray_next;
    logic [P_SIZE-1:0] rq1;
    logic [P_SIZE-1:0] rq2;
    logic [P_SIZE-1:0] rbin_s;
    logic [P_SIZE-1:0] level_next;
    logic              accept;
    logic              full_next;
    logic              af_next;

    assign accept     = bus.w_inc & ~bus.w_full;
    assign wbin_next  = wbin + {{(P_SIZE-1){1'b0}}, accept};
    assign wgray_next = wbin_next ^ (wbin_next >> 1);
    assign bus.w_addr = wbin[P_SIZE-2:0];

    // Full when the write pointer has lapped the synchronized read pointer exactly once.
    assign full_next  = (wgray_next == {~rq2[P_SIZE-1:P_SIZE-2], rq2[P_SIZE-3:0]});
    assign level_next = wbin_next - rbin_s;
    assign af_next    = (level_next >= AF_THRESH);

    // Bit i of the binary pointer is the XOR of all Gray bits from the MSB down to i.
    always_comb begin
        // NOTE: default assignment first so no path leaves rbin_s unassigned (no latch).
        rbin_s = '0;
        for (int i = 0; i < P_SIZE; i++) begin
            rbin_s[i] = ^(rq2 >> i);
        end
    end

    // Plain two-flop synchronizer; nothing may sit between rq1 and rq2.
    always_ff @(posedge w_clk or negedge w_rstn) begin
        // NOTE: every state flop uses non-blocking assignment and the asynchronous
        // active-low reset, so all registers update together on the edge.
        if (!w_rstn) begin
            rq1 <= '0;
            rq2 <= '0;
        end else begin
            rq1 <= bus.r_gptr;
            rq2 <= rq1;
        end
    end

    // Flags are registered from wbin_next so they never lag the producer's own writes.
    always_ff @(posedge w_clk or negedge w_rstn) begin
        if (!w_rstn) begin
            wbin              <= '0;
            bus.w_gptr        <= '0;
            bus.w_full        <= 1'b0;
            bus.w_almost_full <= 1'b0;
            bus.w_level       <= '0;
        end else begin
            wbin              <= wbin_next;
            bus.w_gptr        <= wgray_next;
            bus.w_full        <= full_next;
            bus.w_almost_full <= af_next;
            bus.w_level       <= level_next;
        end
    end

    // Set has priority over clear so a rejected write is never lost.
    always_ff @(posedge w_clk or negedge w_rstn) begin
        if (!w_rstn) begin
            bus.w_overflow <= 1'b0;
        end else if (bus.w_inc && bus.w_full) begin
            bus.w_overflow <= 1'b1;
        end else if (bus.w_ovf_clr) begin
            bus.w_overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl: directed fill/overflow/release/wrap scenarios
// followed by randomized traffic, all compared against a count-based occupancy model.
module tb_fifo_wr_ctrl;
    localparam int P_SIZE   = 5;
    localparam int DEPTH    = 16;
    localparam int AF_LEVEL = 12;

    logic w_clk  = 1'b0;
    logic w_rstn = 1'b1;

    fifo_wr_ctrl_if #(.P_SIZE(P_SIZE)) bus ();

    fifo_wr_ctrl #(.P_SIZE(P_SIZE), .AF_LEVEL(AF_LEVEL)) dut (
        .w_clk  (w_clk),
        .w_rstn (w_rstn),
        .bus    (bus)
    );

    always #5 w_clk = ~w_clk;

    int checks = 0;
    int errors = 0;

    // Model: unbounded counts of writes accepted and reads released; the read count
    // becomes visible to the write side two edges after it is driven.
    int wr_cnt;
    int rd_cnt;
    int rd_seen1;
    int rd_seen2;
    int m_level;
    bit m_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] gray(input int v);
        int b;
        b = v & ((1 << P_SIZE) - 1);
        return 32'(b ^ (b >> 1));
    endfunction

    task automatic model_reset();
        wr_cnt   = 0;
        rd_cnt   = 0;
        rd_seen1 = 0;
        rd_seen2 = 0;
        m_level  = 0;
        m_ovf    = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_addr"},  32'(bus.w_addr),        32'(wr_cnt % DEPTH));
        check({tag, "_gptr"},  32'(bus.w_gptr),        gray(wr_cnt));
        check({tag, "_full"},  32'(bus.w_full),        32'(m_level == DEPTH));
        check({tag, "_level"}, 32'(bus.w_level),       32'(m_level));
        check({tag, "_af"},    32'(bus.w_almost_full), 32'(m_level >= AF_LEVEL));
        check({tag, "_ovf"},   32'(bus.w_overflow),    32'(m_ovf));
    endtask

    // Called just after a falling edge; drives inputs, takes one rising edge,
    // advances the model, checks, and returns at the next falling edge.
    task automatic step(input bit inc, input bit clr, input string tag);
        bit was_full;
        bus.w_inc     = inc;
        bus.w_ovf_clr = clr;
        bus.r_gptr    = P_SIZE'(gray(rd_cnt));
        @(posedge w_clk);
        was_full = (m_level == DEPTH);
        if (inc && !was_full) wr_cnt++;
        if (inc && was_full) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_level  = wr_cnt - rd_seen2;
        rd_seen2 = rd_seen1;
        rd_seen1 = rd_cnt;
        #1;
        check_outputs(tag);
        @(negedge w_clk);
    endtask

    // Asserts reset between edges with a write pending; outputs must clear at once.
    task automatic apply_reset(input string tag);
        bus.w_inc     = 1'b1;
        bus.w_ovf_clr = 1'b0;
        #2 w_rstn = 1'b0;
        #1;
        check({tag, "_addr"},  32'(bus.w_addr),        0);
        check({tag, "_gptr"},  32'(bus.w_gptr),        0);
        check({tag, "_full"},  32'(bus.w_full),        0);
        check({tag, "_level"}, 32'(bus.w_level),       0);
        check({tag, "_af"},    32'(bus.w_almost_full), 0);
        check({tag, "_ovf"},   32'(bus.w_overflow),    0);
        model_reset();
        bus.r_gptr = '0;
        @(negedge w_clk);
        @(negedge w_clk);
        w_rstn = 1'b1;
    endtask

    initial begin
        bus.w_inc     = 1'b0;
        bus.w_ovf_clr = 1'b0;
        bus.r_gptr    = '0;
        model_reset();
        @(negedge w_clk);

        apply_reset("rst0");

        // Fill from empty, first write lands on the first edge after release
        for (int i = 0; i < DEPTH; i++) begin
            check("fill_addr_pre", 32'(bus.w_addr), 32'(i));
            step(1'b1, 1'b0, "fill");
            if (i == AF_LEVEL - 2) check("fill_af_below", 32'(bus.w_almost_full), 0);
            if (i == AF_LEVEL - 1) check("fill_af_at", 32'(bus.w_almost_full), 1);
        end
        check("fill_full",  32'(bus.w_full),  1);
        check("fill_level", 32'(bus.w_level), 16);
        check("fill_gptr",  32'(bus.w_gptr),  32'b11000);

        // Writes while full are rejected and flagged
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, "ovf");
            check("ovf_addr_hold", 32'(bus.w_addr),     0);
            check("ovf_gptr_hold", 32'(bus.w_gptr),     32'b11000);
            check("ovf_flag",      32'(bus.w_overflow), 1);
        end
        step(1'b0, 1'b1, "ovf_clr");
        check("ovf_cleared", 32'(bus.w_overflow), 0);

        // Read side releases four entries; visible on the third edge
        rd_cnt = 4;
        step(1'b0, 1'b0, "rel1");
        step(1'b0, 1'b0, "rel2");
        check("rel_full_held", 32'(bus.w_full), 1);
        step(1'b0, 1'b0, "rel3");
        check("rel_full",  32'(bus.w_full),        0);
        check("rel_level", 32'(bus.w_level),       12);
        check("rel_af",    32'(bus.w_almost_full), 1);
        check("rel_addr",  32'(bus.w_addr),        0);
        step(1'b1, 1'b0, "rel_wr");
        check("rel_wr_addr", 32'(bus.w_addr), 1);

        // Refill, then set and clear on the same edge
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "refill");
        check("refill_full", 32'(bus.w_full), 1);
        step(1'b1, 1'b1, "simul");
        check("simul_ovf", 32'(bus.w_overflow), 1);
        step(1'b0, 1'b1, "simul_clr");

        // Reset while full with a write pending, then write on the first edge
        apply_reset("rst_mid");
        step(1'b1, 1'b0, "post_rst");
        check("post_rst_addr", 32'(bus.w_addr), 1);

        // Pointer wrap
        apply_reset("rst_wrap");
        for (int i = 0; i < 20; i++) begin
            rd_cnt = wr_cnt;
            step(1'b1, 1'b0, "wrap_a");
        end
        rd_cnt = 20;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "wrap_sync");
        check("wrap_empty", 32'(bus.w_level), 0);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, "wrap_b");
        check("wrap_full",  32'(bus.w_full),  1);
        check("wrap_level", 32'(bus.w_level), 16);
        check("wrap_gptr",  32'(bus.w_gptr),  32'b00110);
        check("wrap_addr",  32'(bus.w_addr),  4);

        // Randomized traffic: write-heavy first half, read-heavy second half
        for (int i = 0; i < 3000; i++) begin
            int wr_pct;
            bit inc;
            bit clr;
            wr_pct = (i < 1500) ? 70 : 35;
            if (i == 1500) apply_reset("rnd_rst");
            inc = ($urandom_range(0, 99) < wr_pct);
            clr = ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 99) < 100 - wr_pct && rd_cnt < wr_cnt) rd_cnt++;
            step(inc, clr, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
